button_event_capture: RTL

- Avalon-MM slave (responder) for the processor-side end of the debounced button path.
- Synchronises N debounced button levels and latches their rising edges into a write-1-to-clear capture register.
- Raises a level interrupt for unmasked captured edges and keeps a saturating press counter.
- Sits between the button_debouncer outputs and the platform interconnect, where the CPU is the initiator.

---
 rtl/button_event_pkg.sv | 21 ++
 rtl/button_event_capture_if.sv | 29 ++
 rtl/bit_synchronizer.sv | 31 +++
 rtl/button_event_capture.sv | 107 ++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared register map and helpers for the button event capture block.
package button_event_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_DATA         = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK     = 2'd1;
  localparam logic [1:0] REG_EDGE_CAPTURE = 2'd2;
  localparam logic [1:0] REG_PRESS_COUNT  = 2'd3;

  // Wide enough for up to 32 simultaneous rises.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/button_event_capture_if.sv
// Avalon-MM responder bus for the button event capture registers.
interface button_event_capture_if;

  logic [1:0]                         avs_address;
  logic                               avs_read;
  logic                               avs_write;
  logic [button_event_pkg::DATA_W-1:0] avs_writedata;
  logic [button_event_pkg::DATA_W-1:0] avs_readdata;
  logic                               avs_readdatavalid;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_readdatavalid
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_readdatavalid
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a vector of independent asynchronous levels.
module bit_synchronizer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_d, s1_q;
  logic [Width-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_event_capture.sv
// Avalon-MM responder that latches button rising edges, raises a masked
// level interrupt and keeps a saturating press counter.
module button_event_capture
  import button_event_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          buttons,
  button_event_capture_if.slave avs,
  output logic                  irq
);

  // One spare bit above the larger of counter and popcount widths.
  localparam int unsigned SumW = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [N-1:0]        s2;
  logic [N-1:0]        p_d, p_q;
  logic [N-1:0]        mask_d, mask_q;
  logic [N-1:0]        ec_d, ec_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [DATA_W-1:0]   rdata_d, rdata_q;
  logic                rvalid_d, rvalid_q;

  logic [N-1:0]        rises;
  logic [DATA_W-1:0]   rises_ext;
  logic [5:0]          rise_cnt;
  logic                wr_mask, wr_edge, wr_cnt;
  logic [N-1:0]        clr;
  logic [CNT_W-1:0]    cnt_base;
  logic [SumW-1:0]     cnt_sum;
  logic [DATA_W-1:0]   rd_mux;
  logic                unused_wdata;

  bit_synchronizer #(
    .Width(N)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (buttons),
    .q_o   (s2)
  );

  // Bits at N and above are architecturally ignored.
  assign unused_wdata = ^avs.avs_writedata;

  always_comb begin
    rises     = s2 & ~p_q;
    rises_ext = '0;
    rises_ext[N-1:0] = rises;
    rise_cnt  = popcount32(rises_ext);

    wr_mask = avs.avs_write && (avs.avs_address == REG_IRQ_MASK);
    wr_edge = avs.avs_write && (avs.avs_address == REG_EDGE_CAPTURE);
    wr_cnt  = avs.avs_write && (avs.avs_address == REG_PRESS_COUNT);

    p_d    = s2;
    mask_d = wr_mask ? avs.avs_writedata[N-1:0] : mask_q;

    // New rises are OR-ed in after the clear, so a coincident set wins.
    clr  = wr_edge ? avs.avs_writedata[N-1:0] : '0;
    ec_d = (ec_q & ~clr) | rises;

    cnt_base = wr_cnt ? '0 : cnt_q;
    cnt_sum  = SumW'(cnt_base) + SumW'(rise_cnt);
    cnt_d    = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs.avs_address)
      REG_DATA:         rd_mux[N-1:0]     = s2;
      REG_IRQ_MASK:     rd_mux[N-1:0]     = mask_q;
      REG_EDGE_CAPTURE: rd_mux[N-1:0]     = ec_q;
      REG_PRESS_COUNT:  rd_mux[CNT_W-1:0] = cnt_q;
      default:          rd_mux            = '0;
    endcase
    rdata_d  = avs.avs_read ? rd_mux : rdata_q;
    rvalid_d = avs.avs_read;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q      <= '0;
      mask_q   <= '0;
      ec_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      mask_q   <= mask_d;
      ec_q     <= ec_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
  assign irq                   = |(ec_q & mask_q);

endmodule
